// File: rtl/vram_write_queue_if.sv
// Write-request / VRAM-output bundle for vram_write_queue.
// The CPU-side snooper is the master; the queue is the slave.
interface vram_write_queue_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic          wrReq;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrAck;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          overflow;
  logic [AW-1:0] vramAddr;
  logic [DW-1:0] vramDataOut;
  logic          nvramWE;

  modport master (
    output wrReq, wrAddr, wrData,
    input  wrAck, full, empty, level, overflow, vramAddr, vramDataOut, nvramWE
  );

  modport slave (
    input  wrReq, wrAddr, wrData,
    output wrAck, full, empty, level, overflow, vramAddr, vramDataOut, nvramWE
  );
endinterface

// File: rtl/vram_write_queue.sv
// Posted VRAM byte-write FIFO, drained one entry per 8-pixel sequence (strobe in seq==7).
// Define VRAM_WRQ_COALESCE_EN to merge a write into the tail entry on an address match.
module vram_write_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8
) (
  input logic               pixClk,
  input logic               reset,
  input logic [2:0]         seq,
  vram_write_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {StIdle, StStrobe, StHold} drainState_e;

  drainState_e   stateQ, stateD;
  logic [AW-1:0] addrMem [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [PW-1:0] wrPtrQ, rdPtrQ;
  logic [LW-1:0] countQ, countD;
  logic          wrAckQ, overflowQ;
  logic          nvramWEQ, nvramWED;
  logic [AW-1:0] vramAddrQ, vramAddrD;
  logic [DW-1:0] vramDataQ, vramDataD;
  logic          isFull, isEmpty, launch, popping, push, drop, coalesce;

  assign isFull  = (countQ == LW'(DEPTH));
  assign isEmpty = (countQ == '0);
  assign popping = (stateQ == StHold);
  assign launch  = (stateQ == StIdle) && (seq == 3'd5) && !isEmpty;

`ifdef VRAM_WRQ_COALESCE_EN
  logic [PW-1:0] tailPtr;
  assign tailPtr = wrPtrQ - PW'(1);
  // A lone entry being launched this edge is already in flight, so it must not be merged into.
  assign coalesce = bus.wrReq && !isEmpty && (addrMem[tailPtr] == bus.wrAddr) &&
                    !((countQ == LW'(1)) && ((stateQ != StIdle) || launch));
`else
  assign coalesce = 1'b0;
`endif

  assign push = bus.wrReq && !coalesce && (!isFull || popping);
  assign drop = bus.wrReq && !coalesce && isFull && !popping;

  always_ff @(posedge pixClk) begin
    if (push) begin
      addrMem[wrPtrQ] <= bus.wrAddr;
      dataMem[wrPtrQ] <= bus.wrData;
    end
`ifdef VRAM_WRQ_COALESCE_EN
    else if (coalesce) begin
      dataMem[tailPtr] <= bus.wrData;
    end
`endif
  end

  always_comb begin
    stateD    = stateQ;
    nvramWED  = nvramWEQ;
    vramAddrD = vramAddrQ;
    vramDataD = vramDataQ;
    unique case (stateQ)
      StIdle: begin
        if (launch) begin
          vramAddrD = addrMem[rdPtrQ];
          vramDataD = dataMem[rdPtrQ];
          stateD    = StStrobe;
        end
      end
      StStrobe: begin
        nvramWED = 1'b0;
        stateD   = StHold;
      end
      StHold: begin
        nvramWED = 1'b1;
        stateD   = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    countD = countQ;
    unique case ({push, popping})
      2'b10:   countD = countQ + LW'(1);
      2'b01:   countD = countQ - LW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge pixClk) begin
    if (reset) begin
      stateQ    <= StIdle;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
      wrAckQ    <= 1'b0;
      overflowQ <= 1'b0;
      nvramWEQ  <= 1'b1;
      vramAddrQ <= '0;
      vramDataQ <= '0;
    end else begin
      stateQ    <= stateD;
      countQ    <= countD;
      wrAckQ    <= push || coalesce;
      nvramWEQ  <= nvramWED;
      vramAddrQ <= vramAddrD;
      vramDataQ <= vramDataD;
      if (push) begin
        wrPtrQ <= wrPtrQ + PW'(1);
      end
      if (popping) begin
        rdPtrQ <= rdPtrQ + PW'(1);
      end
      if (drop) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign bus.wrAck       = wrAckQ;
  assign bus.full        = isFull;
  assign bus.empty       = isEmpty;
  assign bus.level       = countQ;
  assign bus.overflow    = overflowQ;
  assign bus.vramAddr    = vramAddrQ;
  assign bus.vramDataOut = vramDataQ;
  assign bus.nvramWE     = nvramWEQ;
endmodule

// File: tb/tb_vram_write_queue.sv
// Self-checking bench for vram_write_queue: directed table, multi-cycle corner cases,
// and randomized traffic against a queue-based reference model.
module tb_vram_write_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 8;

  logic       pixClk = 1'b0;
  logic       reset;
  logic [2:0] seq;

  vram_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  vram_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .pixClk(pixClk),
    .reset (reset),
    .seq   (seq),
    .bus   (bus)
  );

  always #5 pixClk = ~pixClk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    bit            req;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            lvl;
    bit            nwe;
    bit            ack;
    logic [AW-1:0] va;
    logic [DW-1:0] vd;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the launched-write bookkeeping.
  wr_t           mq[$];
  wr_t           obs[$];
  bit            mInflight, mNwe, mAck, mOvf;
  logic [AW-1:0] mVaddr;
  logic [DW-1:0] mVdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge(input logic r, input logic req, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [2:0] s);
    int sz;
    bit launching, popping, coal, push, drop;
    if (r) begin
      mq.delete();
      mInflight = 0;
      mNwe      = 1;
      mAck      = 0;
      mOvf      = 0;
      mVaddr    = '0;
      mVdata    = '0;
      return;
    end
    sz        = mq.size();
    launching = !mInflight && (s == 3'd5) && (sz > 0);
    popping   = mInflight && (s == 3'd7);
    coal      = 0;
`ifdef VRAM_WRQ_COALESCE_EN
    if (req && sz > 0) coal = (mq[sz-1].a == a) && !(sz == 1 && (mInflight || launching));
`endif
    push = req && !coal && ((sz < int'(DEPTH)) || popping);
    drop = req && !coal && (sz == int'(DEPTH)) && !popping;
    mAck = push || coal;
    if (drop) mOvf = 1;
    mNwe = !(mInflight && (s == 3'd6));
    if (coal) mq[sz-1].d = d;
    if (launching) begin
      mVaddr    = mq[0].a;
      mVdata    = mq[0].d;
      mInflight = 1;
    end
    if (popping) begin
      void'(mq.pop_front());
      mInflight = 0;
    end
    if (push) mq.push_back('{a: a, d: d});
  endtask

  // One clock: sample inputs, advance model, compare, then move seq on and drop wrReq.
  task automatic step();
    logic          r, q;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    s;
    r = reset; q = bus.wrReq; a = bus.wrAddr; d = bus.wrData; s = seq;
    @(posedge pixClk);
    #1;
    modelEdge(r, q, a, d, s);
    if (bus.nvramWE == 1'b0) obs.push_back('{a: bus.vramAddr, d: bus.vramDataOut});
    check("level",    32'(bus.level),       32'(mq.size()));
    check("full",     32'(bus.full),        32'(mq.size() == int'(DEPTH)));
    check("empty",    32'(bus.empty),       32'(mq.size() == 0));
    check("overflow", 32'(bus.overflow),    32'(mOvf));
    check("wrAck",    32'(bus.wrAck),       32'(mAck));
    check("nvramWE",  32'(bus.nvramWE),     32'(mNwe));
    check("vramAddr", 32'(bus.vramAddr),    32'(mVaddr));
    check("vramData", 32'(bus.vramDataOut), 32'(mVdata));
    seq = s + 3'd1;
    bus.wrReq = 1'b0;
  endtask

  task automatic alignTo(input logic [2:0] target);
    while (seq != target) step();
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wrReq  = 1'b1;
    bus.wrAddr = a;
    bus.wrData = d;
    step();
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{0, 15'h0000, 8'h00, 0, 1, 0, 15'h0000, 8'h00};
    vt[1] = '{0, 15'h0000, 8'h00, 0, 1, 0, 15'h0000, 8'h00};
    vt[2] = '{1, 15'h1234, 8'hA5, 1, 1, 1, 15'h0000, 8'h00};
    vt[3] = '{0, 15'h0000, 8'h00, 1, 1, 0, 15'h0000, 8'h00};
    vt[4] = '{0, 15'h0000, 8'h00, 1, 1, 0, 15'h0000, 8'h00};
    vt[5] = '{0, 15'h0000, 8'h00, 1, 1, 0, 15'h1234, 8'hA5};
    vt[6] = '{0, 15'h0000, 8'h00, 1, 0, 0, 15'h1234, 8'hA5};
    vt[7] = '{0, 15'h0000, 8'h00, 0, 1, 0, 15'h1234, 8'hA5};
    vt[8] = '{0, 15'h0000, 8'h00, 0, 1, 0, 15'h1234, 8'hA5};
    vt[9] = '{0, 15'h0000, 8'h00, 0, 1, 0, 15'h1234, 8'hA5};

    bus.wrReq = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    seq = 3'd0;
    reset = 1'b1;

    // Reset held two cycles with wrReq asserted.
    repeat (2) begin
      bus.wrReq = 1'b1; bus.wrAddr = 15'h0555; bus.wrData = 8'h5A;
      step();
    end
    check("rst_nvramWE",  32'(bus.nvramWE),     32'd1);
    check("rst_vramAddr", 32'(bus.vramAddr),    32'h0000);
    check("rst_vramData", 32'(bus.vramDataOut), 32'h00);
    check("rst_level",    32'(bus.level),       32'd0);
    check("rst_empty",    32'(bus.empty),       32'd1);
    check("rst_full",     32'(bus.full),        32'd0);
    check("rst_overflow", 32'(bus.overflow),    32'd0);
    check("rst_wrAck",    32'(bus.wrAck),       32'd0);
    reset = 1'b0;

    // Single write, table driven; row index equals the sampled seq.
    alignTo(3'd0);
    obs.delete();
    for (int i = 0; i < 10; i++) begin
      bus.wrReq = vt[i].req; bus.wrAddr = vt[i].a; bus.wrData = vt[i].d;
      step();
      check($sformatf("tbl%0d_level", i), 32'(bus.level),       32'(vt[i].lvl));
      check($sformatf("tbl%0d_nwe", i),   32'(bus.nvramWE),     32'(vt[i].nwe));
      check($sformatf("tbl%0d_ack", i),   32'(bus.wrAck),       32'(vt[i].ack));
      check($sformatf("tbl%0d_addr", i),  32'(bus.vramAddr),    32'(vt[i].va));
      check($sformatf("tbl%0d_data", i),  32'(bus.vramDataOut), 32'(vt[i].vd));
    end
    check("single_writes", 32'(obs.size()), 32'd1);

    // Nine back-to-back writes: the ninth lands while full with no pop due.
    alignTo(3'd6);
    obs.delete();
    for (int i = 0; i < 9; i++) write(AW'(i), DW'(8'h10 + i));
    check("ovf_ack9",  32'(bus.wrAck),    32'd0);
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_level", 32'(bus.level),    32'd8);
    repeat (80) step();
    check("ovf_drained", 32'(bus.level), 32'd0);
    check("ovf_count",   32'(obs.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs.size(); i++) begin
      check($sformatf("ovf_addr%0d", i), 32'(obs[i].a), 32'(i));
      check($sformatf("ovf_data%0d", i), 32'(obs[i].d), 32'(8'h10 + i));
    end

    // Full queue accepts a write on the pop edge.
    doReset();
    alignTo(3'd6);
    obs.delete();
    for (int i = 0; i < 8; i++) write(AW'(8'h20 + i), DW'(8'h40 + i));
    check("fp_full", 32'(bus.full), 32'd1);
    step();
    write(15'h7FFF, 8'hEE);
    check("fp_ack",   32'(bus.wrAck),    32'd1);
    check("fp_level", 32'(bus.level),    32'd8);
    check("fp_ovf",   32'(bus.overflow), 32'd0);
    repeat (96) step();
    check("fp_count", 32'(obs.size()), 32'd9);
    if (obs.size() == 9) begin
      check("fp_first", 32'(obs[0].a), 32'h20);
      check("fp_lastA", 32'(obs[8].a), 32'h7FFF);
      check("fp_lastD", 32'(obs[8].d), 32'hEE);
    end

    // Same-address follow-up writes.
    doReset();
    alignTo(3'd0);
    obs.delete();
    write(15'h0001, 8'h33);
    write(15'h0100, 8'h11);
    write(15'h0100, 8'h22);
    repeat (40) step();
`ifdef VRAM_WRQ_COALESCE_EN
    check("coal_count", 32'(obs.size()), 32'd2);
    if (obs.size() == 2) begin
      check("coal_a1", 32'(obs[1].a), 32'h0100);
      check("coal_d1", 32'(obs[1].d), 32'h22);
    end
`else
    check("coal_count", 32'(obs.size()), 32'd3);
    if (obs.size() == 3) begin
      check("coal_d1", 32'(obs[1].d), 32'h11);
      check("coal_d2", 32'(obs[2].d), 32'h22);
    end
`endif

    // Reset during the strobe cycle aborts the write.
    doReset();
    alignTo(3'd0);
    write(15'h0A00, 8'h01);
    write(15'h0A01, 8'h02);
    write(15'h0A02, 8'h03);
    alignTo(3'd6);
    obs.delete();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rmw_nwe",   32'(bus.nvramWE), 32'd1);
    check("rmw_level", 32'(bus.level),   32'd0);
    repeat (24) step();
    check("rmw_writes", 32'(obs.size()), 32'd0);

    // Randomized traffic with varying density and occasional reset.
    doReset();
    for (int ph = 0; ph < 16; ph++) begin
      int pct;
      pct = int'($urandom_range(0, 100));
      for (int k = 0; k < 200; k++) begin
        reset = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 99) < pct) begin
          bus.wrReq  = 1'b1;
          bus.wrAddr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
          bus.wrData = DW'($urandom);
        end
        step();
      end
    end
    reset = 1'b0;
    repeat (80) step();
    check("rand_drained", 32'(bus.level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
